// File: rtl/demux_1ton_stream_pkg.sv
// Shared constants, slot state encoding and the select-width helper for the 1-to-N stream demux.
package demux_1ton_stream_pkg;

    localparam int DEF_WIDTH = 32'd64;
    localparam int DEF_N     = 32'd4;
    localparam int DEF_CNT_W = 32'd16;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Bits needed to address v channels; never below 1 so a 2-way demux still has a select bit.
    function automatic int clog2(input int v);
        int r;
        r = 32'd1;
        for (int i = 0; i < 32'd31; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 32'd1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/demux_1ton_stream_if.sv
// Producer-side beat handshake plus the N consumer-side channels of the stream demux.
interface demux_1ton_stream_if
    import demux_1ton_stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N
);
    localparam int SEL_W = clog2(N);

    logic [WIDTH-1:0]   i_data;
    logic [SEL_W-1:0]   i_sel;
    logic               i_bcast;
    logic               i_valid;
    logic               i_ready;
    logic [N*WIDTH-1:0] o_data;
    logic [N-1:0]       o_valid;
    logic [N-1:0]       o_ready;

    modport slave (
        input  i_data, i_sel, i_bcast, i_valid, o_ready,
        output i_ready, o_data, o_valid
    );

    modport master (
        output i_data, i_sel, i_bcast, i_valid, o_ready,
        input  i_ready, o_data, o_valid
    );

endinterface

// File: rtl/demux_1ton_stream_slot.sv
// One-entry output register for a single demux channel; accepts a new beat in the same cycle it drains.
module demux_slot
    import demux_1ton_stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    input  logic             ready,
    output logic             free
);
    slot_state_e      state_r;
    slot_state_e      next_state_s;
    logic [WIDTH-1:0] data_r;

    // Next-state: a load always leaves the slot full; a drain without load empties it.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            SLOT_EMPTY: begin
                if (load) begin
                    next_state_s = SLOT_FULL;
                end else begin
                    next_state_s = SLOT_EMPTY;
                end
            end
            SLOT_FULL: begin
                if (load) begin
                    next_state_s = SLOT_FULL;
                end else if (ready) begin
                    next_state_s = SLOT_EMPTY;
                end else begin
                    next_state_s = SLOT_FULL;
                end
            end
            default: next_state_s = SLOT_EMPTY;
        endcase
    end

    // State and data registers; data only moves on load so a drained beat keeps its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= SLOT_EMPTY;
            data_r  <= '0;
        end else begin
            state_r <= next_state_s;
            if (load) begin
                data_r <= d;
            end
        end
    end

    assign q     = data_r;
    assign valid = (state_r == SLOT_FULL);
    assign free  = ~valid | ready;

endmodule

// File: rtl/demux_1ton_stream.sv
// Registered 1-to-N stream demux: select decode, input-ready reduction and bad-select accounting.
module demux_1ton_stream
    import demux_1ton_stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    demux_1ton_stream_if.slave bus,
    output logic              err_sel,
    output logic [CNT_W-1:0]  drop_cnt
);
    localparam int             SEL_W    = clog2(N);
    localparam int             SEL_SPAN = 32'd1 << SEL_W;
    localparam logic [SEL_W:0] N_L      = (SEL_W + 1)'(N);

    logic [N-1:0]        free_s;
    logic [SEL_SPAN-1:0] free_pad_s;
    logic [N-1:0]        load_s;
    logic [N-1:0]        valid_s;
    logic [WIDTH-1:0]    q_s [N];
    logic                sel_ok_s;
    logic                ready_s;
    logic                accept_s;
    logic                drop_s;
    logic                err_sel_r;
    logic [CNT_W-1:0]    drop_cnt_r;

    for (genvar k = 0; k < N; k++) begin : g_slot
        demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk   (clk),
            .rst   (rst),
            .load  (load_s[k]),
            .d     (bus.i_data),
            .q     (q_s[k]),
            .valid (valid_s[k]),
            .ready (bus.o_ready[k]),
            .free  (free_s[k])
        );
    end

    // Input ready: broadcast waits for every slot; an out-of-range select is always sunk.
    always_comb begin
        free_pad_s          = '0;
        free_pad_s[N-1:0]   = free_s;
        sel_ok_s            = ({1'b0, bus.i_sel} < N_L);
        if (bus.i_bcast) begin
            ready_s = &free_s;
        end else if (sel_ok_s) begin
            ready_s = free_pad_s[bus.i_sel];
        end else begin
            ready_s = 1'b1;
        end
    end

    assign accept_s = bus.i_valid & ready_s;
    assign drop_s   = accept_s & ~bus.i_bcast & ~sel_ok_s;

    // Slot load decode and output packing.
    always_comb begin
        load_s     = '0;
        bus.o_data = '0;
        for (int k = 0; k < N; k++) begin
            load_s[k] = accept_s & (bus.i_bcast | (sel_ok_s & (bus.i_sel == SEL_W'(k))));
            bus.o_data[k*WIDTH +: WIDTH] = q_s[k];
        end
    end

    // Sticky bad-select flag and saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sel_r  <= 1'b0;
            drop_cnt_r <= '0;
        end else if (drop_s) begin
            err_sel_r <= 1'b1;
            if (drop_cnt_r != {CNT_W{1'b1}}) begin
                drop_cnt_r <= drop_cnt_r + CNT_W'(1);
            end
        end
    end

    assign bus.i_ready = ready_s;
    assign bus.o_valid = valid_s;
    assign err_sel     = err_sel_r;
    assign drop_cnt    = drop_cnt_r;

endmodule

// File: tb/tb_demux_1ton_stream.sv
// Self-checking bench: N=4 demux against a slot-occupancy model and per-channel scoreboard, plus N=3 drop checks.
module tb_demux_1ton_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    demux_1ton_stream_if #(.WIDTH(64), .N(4)) b4 ();
    demux_1ton_stream_if #(.WIDTH(64), .N(3)) b3 ();
    demux_1ton_stream_if #(.WIDTH(64), .N(3)) b3s ();

    logic        err4, err3, err3s;
    logic [15:0] drop4, drop3;
    logic [1:0]  drop3s;

    demux_1ton_stream #(.WIDTH(64), .N(4), .CNT_W(16)) dut4 (
        .clk(clk), .rst(rst), .bus(b4.slave), .err_sel(err4), .drop_cnt(drop4));
    demux_1ton_stream #(.WIDTH(64), .N(3), .CNT_W(16)) dut3 (
        .clk(clk), .rst(rst), .bus(b3.slave), .err_sel(err3), .drop_cnt(drop3));
    demux_1ton_stream #(.WIDTH(64), .N(3), .CNT_W(2)) dut3s (
        .clk(clk), .rst(rst), .bus(b3s.slave), .err_sel(err3s), .drop_cnt(drop3s));

    always #5 clk = ~clk;

    logic [63:0] q0[$], q1[$], q2[$], q3[$];
    logic [3:0]  exp_full = 4'b0000;

    task automatic push_exp(input int k, input logic [63:0] d);
        case (k)
            0: q0.push_back(d);
            1: q1.push_back(d);
            2: q2.push_back(d);
            default: q3.push_back(d);
        endcase
    endtask

    task automatic pop_check(input int k, input logic [63:0] got);
        logic [63:0] exp;
        bit empty;
        empty = 1'b0;
        exp = 64'd0;
        case (k)
            0: if (q0.size() == 0) empty = 1'b1; else exp = q0.pop_front();
            1: if (q1.size() == 0) empty = 1'b1; else exp = q1.pop_front();
            2: if (q2.size() == 0) empty = 1'b1; else exp = q2.pop_front();
            default: if (q3.size() == 0) empty = 1'b1; else exp = q3.pop_front();
        endcase
        checks++;
        if (empty) begin
            failures++;
            $display("FAIL sb_extra_beat ch%0d: got %h, expected no beat", k, got);
        end else if (got !== exp) begin
            failures++;
            $display("FAIL sb_data ch%0d: got %h expected %h", k, got, exp);
        end
    endtask

    // Advance one cycle on the N=4 DUT, checking o_valid/i_ready against the model and scoring drained beats.
    task automatic tick();
        logic [3:0] free;
        logic       rdy;
        logic [3:0] load;
        #2;
        free = ~exp_full | b4.o_ready;
        if (b4.i_bcast) rdy = &free;
        else            rdy = free[b4.i_sel];
        checks++;
        if (b4.o_valid !== exp_full) begin
            failures++;
            $display("FAIL o_valid: got %b expected %b", b4.o_valid, exp_full);
        end
        checks++;
        if (b4.i_ready !== rdy) begin
            failures++;
            $display("FAIL i_ready: got %b expected %b", b4.i_ready, rdy);
        end
        if (rst) begin
            exp_full = 4'b0000;
            q0.delete(); q1.delete(); q2.delete(); q3.delete();
        end else begin
            for (int k = 0; k < 4; k++)
                if (exp_full[k] && b4.o_ready[k]) pop_check(k, b4.o_data[k*64 +: 64]);
            load = 4'b0000;
            if (b4.i_valid && rdy) load = b4.i_bcast ? 4'b1111 : (4'b0001 << b4.i_sel);
            for (int k = 0; k < 4; k++)
                if (load[k]) push_exp(k, b4.i_data);
            exp_full = load | (exp_full & ~b4.o_ready);
        end
        @(negedge clk);
    endtask

    task automatic drive4(input logic v, input logic [1:0] s, input logic bc, input logic [63:0] d);
        b4.i_valid = v;
        b4.i_sel   = s;
        b4.i_bcast = bc;
        b4.i_data  = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (b4.o_valid !== 4'b0000 || b4.o_data !== 256'd0) begin
            failures++;
            $display("FAIL reset_out: got valid %b data %h expected 0", b4.o_valid, b4.o_data);
        end
        checks++;
        if (err4 !== 1'b0 || drop4 !== 16'd0 || err3 !== 1'b0 || drop3 !== 16'd0) begin
            failures++;
            $display("FAIL reset_err: got err %b drop %0d expected 0 0", err4, drop4);
        end
        checks++;
        if (b4.i_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b expected 1", b4.i_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_route();
        logic [63:0] a;
        a = 64'hA000_0000_0000_0000;
        b4.o_ready = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            drive4(1'b1, 2'(k), 1'b0, a | 64'(k));
            tick();
            #1;
            checks++;
            if (b4.o_valid !== (4'b0001 << k) || b4.o_data[k*64 +: 64] !== (a | 64'(k))) begin
                failures++;
                $display("FAIL route ch%0d: got valid %b data %h expected valid %b data %h",
                         k, b4.o_valid, b4.o_data[k*64 +: 64], 4'b0001 << k, a | 64'(k));
            end
        end
        drive4(1'b0, 2'd0, 1'b0, 64'd0);
        tick();
    endtask

    task automatic test_stall();
        b4.o_ready = 4'b1011;
        drive4(1'b1, 2'd2, 1'b0, 64'h2222_0000_0000_0001);
        tick();
        drive4(1'b1, 2'd2, 1'b0, 64'h2222_0000_0000_0002);
        #1;
        checks++;
        if (b4.i_ready !== 1'b0) begin
            failures++;
            $display("FAIL stall_ready: got %b expected 0", b4.i_ready);
        end
        tick();
        drive4(1'b1, 2'd1, 1'b0, 64'h1111_0000_0000_0001);
        #1;
        checks++;
        if (b4.i_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_other_ch: got %b expected 1", b4.i_ready);
        end
        tick();
        drive4(1'b1, 2'd2, 1'b0, 64'h2222_0000_0000_0002);
        tick();
        #1;
        checks++;
        if (b4.o_data[2*64 +: 64] !== 64'h2222_0000_0000_0001) begin
            failures++;
            $display("FAIL stall_hold: got %h expected %h", b4.o_data[2*64 +: 64], 64'h2222_0000_0000_0001);
        end
        b4.o_ready = 4'b1111;
        tick();
        #1;
        checks++;
        if (b4.o_valid[2] !== 1'b1 || b4.o_data[2*64 +: 64] !== 64'h2222_0000_0000_0002) begin
            failures++;
            $display("FAIL stall_refill: got %h expected %h", b4.o_data[2*64 +: 64], 64'h2222_0000_0000_0002);
        end
        drive4(1'b0, 2'd0, 1'b0, 64'd0);
        tick();
        tick();
    endtask

    task automatic test_bcast();
        logic [63:0] bv;
        bv = 64'hB000_0000_0000_0000;
        b4.o_ready = 4'b1011;
        drive4(1'b1, 2'd2, 1'b0, 64'hC0C0_0000_0000_0000);
        tick();
        drive4(1'b1, 2'd0, 1'b1, bv);
        tick();
        #1;
        checks++;
        if (b4.i_ready !== 1'b0 || b4.o_valid !== 4'b0100) begin
            failures++;
            $display("FAIL bcast_wait: got ready %b valid %b expected 0 0100", b4.i_ready, b4.o_valid);
        end
        b4.o_ready = 4'b1111;
        tick();
        drive4(1'b0, 2'd0, 1'b0, 64'd0);
        b4.o_ready = 4'b0000;
        tick();
        #1;
        checks++;
        if (b4.o_valid !== 4'b1111 || b4.o_data !== {bv, bv, bv, bv}) begin
            failures++;
            $display("FAIL bcast_all: got valid %b data %h expected 1111 all %h", b4.o_valid, b4.o_data, bv);
        end
        b4.o_ready = 4'b1111;
        tick();
        tick();
    endtask

    task automatic test_bad_sel();
        b3.i_valid = 1'b1;  b3.i_sel = 2'd3;  b3.i_bcast = 1'b0;  b3.i_data = 64'hDEAD;
        b3s.i_valid = 1'b1; b3s.i_sel = 2'd3; b3s.i_bcast = 1'b0; b3s.i_data = 64'hDEAD;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (b3.i_ready !== 1'b1 || b3s.i_ready !== 1'b1) begin
                failures++;
                $display("FAIL bad_sel_ready: got %b %b expected 1 1", b3.i_ready, b3s.i_ready);
            end
            tick();
        end
        b3.i_valid = 1'b0;
        b3s.i_valid = 1'b0;
        #1;
        checks++;
        if (b3.o_valid !== 3'b000 || err3 !== 1'b1 || drop3 !== 16'd5) begin
            failures++;
            $display("FAIL bad_sel_cnt: got valid %b err %b drop %0d expected 000 1 5", b3.o_valid, err3, drop3);
        end
        checks++;
        if (err3s !== 1'b1 || drop3s !== 2'd3) begin
            failures++;
            $display("FAIL bad_sel_sat: got err %b drop %0d expected 1 3", err3s, drop3s);
        end
        b3.i_valid = 1'b1; b3.i_sel = 2'd2; b3.i_data = 64'h3333;
        tick();
        b3.i_valid = 1'b0;
        #1;
        checks++;
        if (b3.o_valid !== 3'b100 || b3.o_data[2*64 +: 64] !== 64'h3333 || drop3 !== 16'd5) begin
            failures++;
            $display("FAIL top_sel_n3: got valid %b drop %0d expected 100 5", b3.o_valid, drop3);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            b4.o_ready = 4'($urandom);
            drive4($urandom_range(0, 3) != 0, 2'($urandom), $urandom_range(0, 7) == 0,
                   {$urandom, $urandom});
            tick();
        end
        drive4(1'b0, 2'd0, 1'b0, 64'd0);
        b4.o_ready = 4'b1111;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        b4.o_ready = 4'b0000;
        drive4(1'b1, 2'd0, 1'b0, 64'h0F0F_0000_0000_0000);
        tick();
        drive4(1'b1, 2'd3, 1'b0, 64'h3F3F_0000_0000_0000);
        tick();
        drive4(1'b0, 2'd0, 1'b0, 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        b4.o_ready = 4'b1111;
        #1;
        checks++;
        if (b4.o_valid !== 4'b0000 || b4.o_data !== 256'd0) begin
            failures++;
            $display("FAIL reset_mid: got valid %b data %h expected 0", b4.o_valid, b4.o_data);
        end
        checks++;
        if (err3 !== 1'b0 || drop3 !== 16'd0 || drop3s !== 2'd0) begin
            failures++;
            $display("FAIL reset_mid_err: got err %b drop %0d expected 0 0", err3, drop3);
        end
        tick();
        tick();
    endtask

    initial begin
        drive4(1'b0, 2'd0, 1'b0, 64'd0);
        b4.o_ready = 4'b0000;
        b3.i_valid = 1'b0;  b3.i_sel = 2'd0;  b3.i_bcast = 1'b0;  b3.i_data = 64'd0;  b3.o_ready = 3'b000;
        b3s.i_valid = 1'b0; b3s.i_sel = 2'd0; b3s.i_bcast = 1'b0; b3s.i_data = 64'd0; b3s.o_ready = 3'b000;
        @(negedge clk);
        test_reset();
        test_route();
        test_stall();
        test_bcast();
        test_bad_sel();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if ((q0.size() + q1.size() + q2.size() + q3.size()) != 0) begin
            failures++;
            $display("FAIL sb_leftover: got %0d undelivered beats expected 0",
                     q0.size() + q1.size() + q2.size() + q3.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
